// File: rtl/debug_tx_sequencer.sv
// debug_tx_sequencer: streams the MIPS debug dump (PC, register file, data-memory window)
// to the UART transmitter one byte at a time, each word sent MSB-first.
// Optional build macro DEBUG_TX_CHECKSUM_EN appends an 8-bit XOR checksum byte to the dump.
module debug_tx_sequencer #(
  parameter int DATA_WIDTH      = 32,
  parameter int DATA_WIDTH_UART = 8,
  parameter int N_REGS          = 32,
  parameter int N_MEM_WORDS     = 32,
  parameter int MEM_ADDR_WIDTH  = 5
) (
  input  logic                       i_clock,
  input  logic                       i_reset,
  input  logic                       i_send,
  input  logic [DATA_WIDTH-1:0]      i_pc,
  input  logic [DATA_WIDTH-1:0]      i_reg,
  input  logic [DATA_WIDTH-1:0]      i_mem,
  input  logic                       i_tx_done,
  output logic                       o_tx_signal,
  output logic [DATA_WIDTH_UART-1:0] o_tx_result,
  output logic [4:0]                 o_reg_addr,
  output logic [MEM_ADDR_WIDTH-1:0]  o_mem_addr,
  output logic                       o_busy,
  output logic                       o_done
);

  localparam int NBYTES = DATA_WIDTH / DATA_WIDTH_UART;
  localparam int BIDX_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [BIDX_W-1:0]         LAST_BYTE = BIDX_W'(NBYTES - 1);
  localparam logic [4:0]                LAST_REG  = 5'(N_REGS - 1);
  localparam logic [MEM_ADDR_WIDTH-1:0] LAST_MEM  = MEM_ADDR_WIDTH'(N_MEM_WORDS - 1);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SEND, S_WAIT, S_DONE} state_t;
  typedef enum logic [1:0] {SEC_PC, SEC_REG, SEC_MEM, SEC_CSUM} sec_t;

  state_t                      state_q;
  sec_t                        sec_q;
  logic [BIDX_W-1:0]           byte_idx_q;
  logic [DATA_WIDTH-1:0]       shift_q;
  logic                        tx_signal_q;
  logic [DATA_WIDTH_UART-1:0]  tx_result_q;
  logic [4:0]                  reg_addr_q;
  logic [MEM_ADDR_WIDTH-1:0]   mem_addr_q;
  logic                        busy_q;
  logic                        done_q;
  logic [DATA_WIDTH-1:0]       word_d;
  logic [DATA_WIDTH-1:0]       shifted_d;
`ifdef DEBUG_TX_CHECKSUM_EN
  logic [DATA_WIDTH_UART-1:0]  csum_q;
`endif

  // Word source for the current section, and the shift register advanced by one byte
  always_comb begin
    word_d = i_pc;
    case (sec_q)
      SEC_REG: word_d = i_reg;
      SEC_MEM: word_d = i_mem;
      default: word_d = i_pc;
    endcase
    shifted_d = shift_q << DATA_WIDTH_UART;
  end

  // Dump sequencer; all outputs are registered and set on the transition into their state
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q     <= S_IDLE;
      sec_q       <= SEC_PC;
      byte_idx_q  <= '0;
      shift_q     <= '0;
      tx_signal_q <= 1'b0;
      tx_result_q <= '0;
      reg_addr_q  <= '0;
      mem_addr_q  <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
`ifdef DEBUG_TX_CHECKSUM_EN
      csum_q      <= '0;
`endif
    end else begin
      tx_signal_q <= 1'b0;
      done_q      <= 1'b0;
      case (state_q)
        S_IDLE: begin
          reg_addr_q <= '0;
          mem_addr_q <= '0;
          if (i_send) begin
            state_q    <= S_LOAD;
            sec_q      <= SEC_PC;
            byte_idx_q <= '0;
            busy_q     <= 1'b1;
`ifdef DEBUG_TX_CHECKSUM_EN
            csum_q     <= '0;
`endif
          end
        end
        S_LOAD: begin
          // Address has been stable since the previous edge, so the read data is settled here
          shift_q     <= word_d;
          tx_result_q <= word_d[DATA_WIDTH-1 -: DATA_WIDTH_UART];
          tx_signal_q <= 1'b1;
`ifdef DEBUG_TX_CHECKSUM_EN
          csum_q      <= csum_q ^ word_d[DATA_WIDTH-1 -: DATA_WIDTH_UART];
`endif
          state_q     <= S_SEND;
        end
        S_SEND: state_q <= S_WAIT;
        S_WAIT: begin
          if (i_tx_done) begin
            if ((sec_q != SEC_CSUM) && (byte_idx_q != LAST_BYTE)) begin
              // Next byte of the same word goes straight out
              byte_idx_q  <= byte_idx_q + BIDX_W'(1);
              shift_q     <= shifted_d;
              tx_result_q <= shifted_d[DATA_WIDTH-1 -: DATA_WIDTH_UART];
              tx_signal_q <= 1'b1;
`ifdef DEBUG_TX_CHECKSUM_EN
              csum_q      <= csum_q ^ shifted_d[DATA_WIDTH-1 -: DATA_WIDTH_UART];
`endif
              state_q     <= S_SEND;
            end else begin
              byte_idx_q <= '0;
              case (sec_q)
                SEC_PC: begin
                  sec_q      <= SEC_REG;
                  reg_addr_q <= '0;
                  state_q    <= S_LOAD;
                end
                SEC_REG: begin
                  if (reg_addr_q == LAST_REG) begin
                    sec_q      <= SEC_MEM;
                    mem_addr_q <= '0;
                  end else begin
                    reg_addr_q <= reg_addr_q + 5'd1;
                  end
                  state_q <= S_LOAD;
                end
                SEC_MEM: begin
                  if (mem_addr_q == LAST_MEM) begin
`ifdef DEBUG_TX_CHECKSUM_EN
                    // Checksum needs no read, so it skips LOAD
                    sec_q       <= SEC_CSUM;
                    tx_result_q <= csum_q;
                    tx_signal_q <= 1'b1;
                    state_q     <= S_SEND;
`else
                    state_q <= S_DONE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
`endif
                  end else begin
                    mem_addr_q <= mem_addr_q + MEM_ADDR_WIDTH'(1);
                    state_q    <= S_LOAD;
                  end
                end
                default: begin
                  state_q <= S_DONE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                end
              endcase
            end
          end
        end
        S_DONE: state_q <= S_IDLE;
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign o_tx_signal = tx_signal_q;
  assign o_tx_result = tx_result_q;
  assign o_reg_addr  = reg_addr_q;
  assign o_mem_addr  = mem_addr_q;
  assign o_busy      = busy_q;
  assign o_done      = done_q;

endmodule

// File: tb/tb_debug_tx_sequencer.sv
// tb_debug_tx_sequencer: directed vector table for handshake/reset corners, then full dumps
// against a byte-list reference model with fixed and random UART response delays.
module tb_debug_tx_sequencer;
  localparam int DW = 32, UW = 8, NR = 32, NM = 32, MAW = 5, NB = DW / UW;
`ifdef DEBUG_TX_CHECKSUM_EN
  localparam int CS = 1;
`else
  localparam int CS = 0;
`endif
  localparam int NDATA = NB * (1 + NR + NM);
  localparam int NEXP  = NDATA + CS;

  logic          clk = 1'b0;
  logic          rst = 1'b1, send = 1'b0;
  logic          txd_resp = 1'b0, txd_inj = 1'b0, txd_tbl = 1'b0;
  logic          tx_done;
  logic [DW-1:0] pc = '0;
  logic [DW-1:0] reg_arr [NR];
  logic [DW-1:0] mem_arr [NM];
  logic          o_tx_signal, o_busy, o_done;
  logic [UW-1:0] o_tx_result;
  logic [4:0]    o_reg_addr;
  logic [MAW-1:0] o_mem_addr;

  assign tx_done = txd_resp | txd_inj | txd_tbl;

  debug_tx_sequencer #(.DATA_WIDTH(DW), .DATA_WIDTH_UART(UW), .N_REGS(NR),
                       .N_MEM_WORDS(NM), .MEM_ADDR_WIDTH(MAW)) dut (
    .i_clock(clk), .i_reset(rst), .i_send(send), .i_pc(pc),
    .i_reg(reg_arr[o_reg_addr]), .i_mem(mem_arr[o_mem_addr]), .i_tx_done(tx_done),
    .o_tx_signal(o_tx_signal), .o_tx_result(o_tx_result), .o_reg_addr(o_reg_addr),
    .o_mem_addr(o_mem_addr), .o_busy(o_busy), .o_done(o_done));

  always #5 clk = ~clk;

  int cyc = 0;
  initial forever begin @(posedge clk); cyc++; end

  // UART responder: one i_tx_done pulse a few cycles after each start pulse
  bit resp_en = 0, resp_rand = 0, inj_en = 0;
  int resp_d = 1;
  initial forever begin
    if (resp_en && o_tx_signal) begin
      repeat (resp_rand ? $urandom_range(1, 4) : resp_d) @(negedge clk);
      txd_resp = 1'b1;
      @(negedge clk);
      txd_resp = 1'b0;
    end else @(negedge clk);
  end

  // Nuisance i_tx_done coincident with every SEND cycle
  initial forever begin
    @(negedge clk);
    if (inj_en && o_tx_signal) txd_inj = 1'b1;
    else txd_inj = 1'b0;
  end

  // Monitor: byte log, start-pulse cycles, response-to-start gaps, done pulses
  logic [7:0] got_q[$];
  int sig_cyc_q[$], gap_q[$];
  int last_resp = -1000, done_cnt = 0, done_cyc = 0;
  logic done_busy = 1'b0;
  initial forever begin
    @(negedge clk); #2;
    if (txd_resp) last_resp = cyc;
    if (o_tx_signal) begin
      got_q.push_back(o_tx_result);
      sig_cyc_q.push_back(cyc);
      gap_q.push_back(cyc - last_resp);
    end
    if (o_done) begin done_cnt++; done_cyc = cyc; done_busy = o_busy; end
  end

  int errs = 0, checks = 0;
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Reference: the dump is just every word's bytes, MSB first, in section order
  logic [7:0] exp_q[$];
  task automatic push_word(input logic [DW-1:0] w, inout logic [7:0] cs);
    for (int b = 0; b < NB; b++) begin
      logic [7:0] by;
      by = 8'(w >> (DW - 8 * (b + 1)));
      exp_q.push_back(by);
      cs ^= by;
    end
  endtask
  task automatic build_exp();
    logic [7:0] cs;
    cs = '0;
    exp_q.delete();
    push_word(pc, cs);
    for (int k = 0; k < NR; k++) push_word(reg_arr[k], cs);
    for (int k = 0; k < NM; k++) push_word(mem_arr[k], cs);
    if (CS != 0) exp_q.push_back(cs);
  endtask

  task automatic run_dump(input string tag, input int dly, input bit rnd, input bit robust);
    int n, send_cyc, badgap;
    got_q.delete(); sig_cyc_q.delete(); gap_q.delete();
    done_cnt = 0;
    build_exp();
    resp_d = dly; resp_rand = rnd; resp_en = 1; inj_en = robust;
    if (robust) begin
      txd_tbl = 1'b1; step(); txd_tbl = 1'b0; step();
    end
    send = 1'b1; send_cyc = cyc; step(); send = 1'b0;
    n = 0;
    while (done_cnt == 0 && n < 40000) begin
      step(); n++;
      if (robust && n == 300) send = 1'b1;
      if (robust && n == 304) send = 1'b0;
    end
    chk({tag, " done_seen"}, 32'(done_cnt != 0), 1);
    repeat (40) step();
    chk({tag, " byte_count"}, got_q.size(), NEXP);
    chk({tag, " done_count"}, done_cnt, 1);
    chk({tag, " done_lat"}, done_cyc - last_resp, 1);
    chk({tag, " busy_in_done"}, 32'(done_busy), 0);
    chk({tag, " busy_after"}, 32'(o_busy), 0);
    if (sig_cyc_q.size() > 0) chk({tag, " first_lat"}, sig_cyc_q[0] - send_cyc, 2);
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      chk($sformatf("%s byte%0d", tag, i), got_q[i], exp_q[i]);
    badgap = 0;
    for (int i = 1; i < gap_q.size(); i++)
      if (gap_q[i] != (((i % NB) == 0 && i < NDATA) ? 2 : 1)) badgap++;
    chk({tag, " gaps_bad"}, badgap, 0);
    resp_en = 0; inj_en = 0;
  endtask

  typedef struct {
    logic rst, send, txd;
    logic busy, sig, done;
    logic [7:0] res;
  } vec_t;
  vec_t tv[14];

  initial begin
    // reset, IDLE pulse, done coincident with SEND, mid-dump send, reset at PC byte 2
    tv[0]  = '{1, 0, 0, 0, 0, 0, 8'h00};
    tv[1]  = '{1, 0, 0, 0, 0, 0, 8'h00};
    tv[2]  = '{0, 0, 1, 0, 0, 0, 8'h00};
    tv[3]  = '{0, 1, 0, 1, 0, 0, 8'h00};
    tv[4]  = '{0, 0, 0, 1, 1, 0, 8'h80};
    tv[5]  = '{0, 0, 1, 1, 0, 0, 8'h80};
    tv[6]  = '{0, 0, 0, 1, 0, 0, 8'h80};
    tv[7]  = '{0, 0, 1, 1, 1, 0, 8'hE1};
    tv[8]  = '{0, 1, 0, 1, 0, 0, 8'hE1};
    tv[9]  = '{0, 0, 1, 1, 1, 0, 8'h70};
    tv[10] = '{0, 0, 0, 1, 0, 0, 8'h70};
    tv[11] = '{1, 0, 0, 0, 0, 0, 8'h00};
    tv[12] = '{1, 0, 0, 0, 0, 0, 8'h00};
    tv[13] = '{0, 0, 1, 0, 0, 0, 8'h00};

    pc = 32'h80E17021;
    for (int k = 0; k < NR; k++) reg_arr[k] = 32'hBFFFF000 + k;
    for (int k = 0; k < NM; k++) mem_arr[k] = 32'h80017000 + k;

    for (int i = 0; i < 14; i++) begin
      rst = tv[i].rst; send = tv[i].send; txd_tbl = tv[i].txd;
      step();
      chk($sformatf("v%0d busy", i), 32'(o_busy), 32'(tv[i].busy));
      chk($sformatf("v%0d tx_signal", i), 32'(o_tx_signal), 32'(tv[i].sig));
      chk($sformatf("v%0d done", i), 32'(o_done), 32'(tv[i].done));
      chk($sformatf("v%0d tx_result", i), 32'(o_tx_result), 32'(tv[i].res));
      chk($sformatf("v%0d reg_addr", i), 32'(o_reg_addr), 0);
      chk($sformatf("v%0d mem_addr", i), 32'(o_mem_addr), 0);
    end
    rst = 1'b0; send = 1'b0; txd_tbl = 1'b0;
    repeat (3) step();

    // Full dump with slow UART and recognisable data
    run_dump("slow", 50, 0, 0);
    if (got_q.size() == NEXP) begin
      logic [7:0] hd[12];
      hd = '{8'h80, 8'hE1, 8'h70, 8'h21, 8'hBF, 8'hFF, 8'hF0, 8'h00,
             8'h80, 8'h01, 8'h70, 8'h00};
      for (int j = 0; j < 4; j++) begin
        chk($sformatf("pc byte%0d", j), got_q[j], hd[j]);
        chk($sformatf("reg0 byte%0d", j), got_q[4 + j], hd[4 + j]);
        chk($sformatf("mem0 byte%0d", j), got_q[132 + j], hd[8 + j]);
      end
      chk("last mem word", {got_q[NDATA-4], got_q[NDATA-3], got_q[NDATA-2], got_q[NDATA-1]},
          32'h8001701F);
    end

    // Random data, random UART latency, nuisance handshakes and a mid-dump send
    pc = $urandom;
    for (int k = 0; k < NR; k++) reg_arr[k] = $urandom;
    for (int k = 0; k < NM; k++) mem_arr[k] = $urandom;
    run_dump("robust", 1, 1, 1);

    pc = $urandom;
    for (int k = 0; k < NR; k++) reg_arr[k] = $urandom;
    for (int k = 0; k < NM; k++) mem_arr[k] = $urandom;
    run_dump("rand", 2, 1, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
